// File: rtl/message_receiver_pkg.sv
// Shared types and frame layout for the serial message receiver.
// The frame is 9 bits: start, 5 data bits (LSB first), even parity, then 2 stop bits.
package message_receiver_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      DONE  = 2'd3
   } rx_state_t;

   localparam int DATA_BITS   = 5;
   localparam int FRAME_BITS  = 9;
   localparam int SAMPLE_BITS = 8;

   localparam int START_POS = 0;
   localparam int PAR_POS   = 6;
   localparam int STOP0_POS = 7;
   localparam int STOP1_POS = 8;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer. It counts while enabled and wraps at the terminal count of
// the selected period: half a bit for start-bit centring, otherwise a full bit.
module rx_bit_timer #(
   parameter int BIT_CYCLES = 1024,
   parameter int CNT_W      = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic half,
   output logic half_tc,
   output logic full_tc
);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic             wrap;

   assign half_tc = (cnt_reg == HALF_LAST);
   assign full_tc = (cnt_reg == FULL_LAST);
   assign wrap    = half ? half_tc : full_tc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en) begin
         cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/message_receiver.sv
// Serial-to-parallel receiver for the 9-bit message frame: synchronises the line,
// centres on the start bit, samples 8 further bits and reports message plus error flags.
module message_receiver
   import message_receiver_pkg::*;
#(
   parameter int BIT_CYCLES = 1024,
   parameter int CNT_W      = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_main,
   output logic [DATA_BITS-1:0]  msg_out,
   output logic [FRAME_BITS-1:0] frame_out,
   output logic                  valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  busy
);

   rx_state_t             state_reg, state_next;
   logic                  sync1_reg, sync_in_reg, prev_in_reg;
   logic [FRAME_BITS-1:0] frame_reg;
   logic [2:0]            bit_idx_reg;
   logic                  tmr_clr, tmr_en, tmr_half, half_tc, full_tc;
   logic                  start_ok, bit_take, done;

   rx_bit_timer #(
      .BIT_CYCLES(BIT_CYCLES),
      .CNT_W     (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .half   (tmr_half),
      .half_tc(half_tc),
      .full_tc(full_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg   <= 1'b1;
         sync_in_reg <= 1'b1;
         prev_in_reg <= 1'b1;
         state_reg   <= IDLE;
      end else begin
         sync1_reg   <= in_main;
         sync_in_reg <= sync1_reg;
         prev_in_reg <= sync_in_reg;
         state_reg   <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;
      tmr_half   = 1'b0;
      start_ok   = 1'b0;
      bit_take   = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            tmr_clr = 1'b1;
            // Only a fresh 1->0 transition starts a frame; a line stuck low does not.
            if (prev_in_reg && !sync_in_reg) state_next = START;
         end
         START: begin
            tmr_en   = 1'b1;
            tmr_half = 1'b1;
            if (half_tc) begin
               if (!sync_in_reg) begin
                  state_next = DATA;
                  tmr_clr    = 1'b1;
                  start_ok   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            tmr_en = 1'b1;
            if (full_tc) begin
               bit_take = 1'b1;
               if (bit_idx_reg == 3'(SAMPLE_BITS - 1)) state_next = DONE;
            end
         end
         DONE: begin
            tmr_clr    = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_reg   <= '0;
         bit_idx_reg <= '0;
         msg_out     <= '0;
         frame_out   <= '0;
         valid       <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         valid <= done;
         if (start_ok) begin
            frame_reg   <= '0;
            bit_idx_reg <= '0;
         end else if (bit_take) begin
            frame_reg[{1'b0, bit_idx_reg} + 4'd1] <= sync_in_reg;
            bit_idx_reg                           <= bit_idx_reg + 3'd1;
         end
         if (done) begin
            msg_out    <= frame_reg[PAR_POS-1:START_POS+1];
            frame_out  <= frame_reg;
            parity_err <= ^frame_reg[PAR_POS:START_POS+1];
            frame_err  <= ~(frame_reg[STOP0_POS] & frame_reg[STOP1_POS]);
         end
      end
   end

   assign busy = (state_reg != IDLE);

endmodule
